// File: rtl/omsp_bcd_pkg.sv
// Shared types and constants for the digit-serial packed-BCD add/subtract unit.
package omsp_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // Nines complement of one digit; wraps mod 16 for non-BCD input.
  function automatic logic [3:0] bcd_nines(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/omsp_bcd_addsub_seq_if.sv
// Start/done request bus between a requester and the BCD add/subtract unit.
interface omsp_bcd_addsub_seq_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         invalid;

  modport master (
    output start, sub, op_a, op_b, carry_in,
    input  busy, done, result, carry_out, zero, invalid
  );

  modport slave (
    input  start, sub, op_a, op_b, carry_in,
    output busy, done, result, carry_out, zero, invalid
  );

endinterface

// File: rtl/omsp_bcd_digit_add.sv
// One-digit decimal add with nines-complement subtract; purely combinational.
module omsp_bcd_digit_add
  import omsp_bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  input  logic       sub,
  output logic [3:0] d,
  output logic       co,
  output logic       bad
);

  logic [3:0] w_bx;
  logic [4:0] w_s;

  assign w_bx = sub ? bcd_nines(b) : b;
  assign w_s  = {1'b0, a} + {1'b0, w_bx} + {4'b0, ci};
  assign co   = (w_s > {1'b0, BCD_MAX});
  // Decimal adjust: skipping the six unused codes wraps the digit back into 0..9.
  assign d    = co ? (w_s[3:0] + BCD_CORR) : w_s[3:0];
  assign bad  = (a > BCD_MAX) | (b > BCD_MAX);

endmodule

// File: rtl/omsp_bcd_addsub_seq.sv
// Multicycle packed-BCD add/subtract, one digit per clock, LS digit first.
module omsp_bcd_addsub_seq
  import omsp_bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  mclk,
  input  logic                  reset_n,
  omsp_bcd_addsub_seq_if.slave  bus
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_e           r_state, w_state_nx;
  logic [W-1:0]     r_a, r_b, r_result, w_res_nx;
  logic             r_sub, r_c, r_cout, r_zero, r_inv;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_last;
  logic [3:0]       w_d;
  logic             w_co, w_bad;

  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  // Operands shift right so the active digit always sits in bits [3:0].
  omsp_bcd_digit_add u_digit (
    .a   (r_a[3:0]),
    .b   (r_b[3:0]),
    .ci  (r_c),
    .sub (r_sub),
    .d   (w_d),
    .co  (w_co),
    .bad (w_bad)
  );

  // New digit enters at the top; after DIGITS shifts every digit is in place.
  assign w_res_nx = (r_result >> 4) | (W'(w_d) << (W - 4));

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nx = RUN;
      RUN:     if (w_last)    w_state_nx = DONE;
      DONE:    w_state_nx = bus.start ? RUN : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_inv    <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.op_a;
      r_b   <= bus.op_b;
      r_sub <= bus.sub;
      // Subtract runs as A + nines(B) + 1 - borrow_in.
      r_c   <= bus.sub ? ~bus.carry_in : bus.carry_in;
      r_cnt <= '0;
      r_inv <= 1'b0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 4;
      r_b      <= r_b >> 4;
      r_c      <= w_co;
      r_result <= w_res_nx;
      r_inv    <= r_inv | w_bad;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_cout <= r_sub ? ~w_co : w_co;
        r_zero <= (w_res_nx == '0);
      end
    end
  end

  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.carry_out = r_cout;
  assign bus.zero      = r_zero;
  assign bus.invalid   = r_inv;

endmodule
